// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// regfile_wb_ctrl - register file write-port arbiter: pipeline vs. multi-cycle
// result FIFO, destination scoreboard and anti-starvation stall.   Rev 1.0
// ============================================================================
module regfile_wb_ctrl #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_we,
  input  logic [ADDRESS_WIDTH-1:0] pipe_rd,
  input  logic [DATA_WIDTH-1:0]    pipe_wd,
  output logic                     pipe_stall,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_rd,
  output logic                     iss_ready,
  input  logic                     mc_valid,
  input  logic [ADDRESS_WIDTH-1:0] mc_rd,
  input  logic [DATA_WIDTH-1:0]    mc_wd,
  output logic                     mc_ready,
  input  logic [ADDRESS_WIDTH-1:0] q_rs1,
  input  logic [ADDRESS_WIDTH-1:0] q_rs2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3
);

  localparam int NREG = 1 << ADDRESS_WIDTH;
  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam int NW   = $clog2(NREG + 1);
  localparam logic [CW-1:0]            FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0]            STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [NW-1:0]            PEND_MAX   = NW'(FIFO_DEPTH + 2);
  localparam logic [ADDRESS_WIDTH-1:0] X0         = '0;

  logic [ADDRESS_WIDTH-1:0] fifo_rd_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_wd_q [FIFO_DEPTH];

  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [NREG-1:0]          pending_q, pending_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     pipe_stall_q, pipe_stall_d;
  logic                     we3_q, we3_d;
  logic [ADDRESS_WIDTH-1:0] ad3_q, ad3_d;
  logic [DATA_WIDTH-1:0]    wd3_q, wd3_d;
  logic                     from_fifo_q, from_fifo_d;

  logic                     fifo_empty, pipe_win, deq, enq, iss_fire;
  logic [ADDRESS_WIDTH-1:0] head_rd;
  logic [DATA_WIDTH-1:0]    head_wd;
  logic [NW-1:0]            pend_cnt;

  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt = pend_cnt + NW'(pending_q[i]);
    end
  end

  assign mc_ready   = (count_q != FULL_CNT);
  assign iss_ready  = !pending_q[iss_rd] && (pend_cnt < PEND_MAX);
  assign pipe_stall = pipe_stall_q;
  assign WE3        = we3_q;
  assign AD3        = ad3_q;
  assign WD3        = wd3_q;

  // A FIFO write sitting on the port has already cleared its pending bit but
  // has not reached the register file yet, so it still counts as busy.
  assign busy1 = (q_rs1 != X0) &&
                 (pending_q[q_rs1] || (we3_q && from_fifo_q && (ad3_q == q_rs1)));
  assign busy2 = (q_rs2 != X0) &&
                 (pending_q[q_rs2] || (we3_q && from_fifo_q && (ad3_q == q_rs2)));

  always_comb begin
    fifo_empty = (count_q == '0);
    pipe_win   = pipe_we && (pipe_rd != X0) && !pipe_stall_q;
    deq        = !pipe_win && !fifo_empty;
    enq        = mc_valid && mc_ready;
    iss_fire   = iss_valid && iss_ready && (iss_rd != X0);
    head_rd    = fifo_rd_q[rd_ptr_q];
    head_wd    = fifo_wd_q[rd_ptr_q];

    rd_ptr_d = deq ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = enq ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d  = count_q + CW'(enq) - CW'(deq);

    we3_d       = 1'b0;
    ad3_d       = ad3_q;
    wd3_d       = wd3_q;
    from_fifo_d = 1'b0;
    if (pipe_win) begin
      we3_d = 1'b1;
      ad3_d = pipe_rd;
      wd3_d = pipe_wd;
    end else if (deq && (head_rd != X0)) begin
      we3_d       = 1'b1;
      ad3_d       = head_rd;
      wd3_d       = head_wd;
      from_fifo_d = 1'b1;
    end

    pending_d = pending_q;
    if (iss_fire) pending_d[iss_rd] = 1'b1;
    if (deq)      pending_d[head_rd] = 1'b0;
    pending_d[0] = 1'b0;

    starve_d     = (fifo_empty || deq) ? '0 : starve_q + 1'b1;
    pipe_stall_d = (starve_d == STARVE_MAX);
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd_q[wr_ptr_q] <= mc_rd;
      fifo_wd_q[wr_ptr_q] <= mc_wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      starve_q     <= '0;
      pipe_stall_q <= 1'b0;
      we3_q        <= 1'b0;
      ad3_q        <= '0;
      wd3_q        <= '0;
      from_fifo_q  <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      starve_q     <= starve_d;
      pipe_stall_q <= pipe_stall_d;
      we3_q        <= we3_d;
      ad3_q        <= ad3_d;
      wd3_q        <= wd3_d;
      from_fifo_q  <= from_fifo_d;
    end
  end

endmodule
`default_nettype wire
